snicker_led_ctrl: RTL and testbench

Parametrised multi-channel LED controller for the SnickerBits top level, replacing the single fixed `led` output with NUM_LEDS independently configured channels. Each channel runs in one of four modes: off, on, blink at a programmable tick-based half-period, or PWM dimming at a programmable duty. Configuration arrives over a valid/ready write port, and all channels share one prescaler and one PWM counter.

---
 rtl/snicker_led_pkg.sv | 16 +
 rtl/snicker_led_chan.sv | 73 +++++++
 rtl/snicker_led_ctrl.sv | 64 ++++++
 tb/tb_snicker_led_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/snicker_led_pkg.sv
// Shared types and default parameter values for the SnickerBits LED controller.
package snicker_led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_t;

    localparam int DEF_NUM_LEDS = 4;
    localparam int DEF_TICK_DIV = 100000;
    localparam int DEF_PWM_BITS = 8;
    localparam int DEF_PER_BITS = 16;

endpackage

// File: rtl/snicker_led_chan.sv
// One LED channel: holds its configuration, blink counter/phase and the led flop.
//   mode      | meaning
//   LED_OFF   | led held low
//   LED_ON    | led held high
//   LED_BLINK | led follows phase, toggled every eff_period ticks
//   LED_PWM   | led high while shared pwm_cnt < duty
module snicker_led_chan
    import snicker_led_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int PER_BITS = DEF_PER_BITS
) (
    input  logic                clk_axi,
    input  logic                rst_n,
    input  logic                wr,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    input  logic [PER_BITS-1:0] cfg_period,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);

    led_mode_t           mode;
    logic [PWM_BITS-1:0] duty;
    logic [PER_BITS-1:0] period;
    logic [PER_BITS-1:0] cnt;
    logic                phase;
    logic [PER_BITS-1:0] last;
    logic                led_next;

    // A zero period behaves as one tick, so the terminal count is 0 in both cases.
    assign last = (period == '0) ? '0 : period - PER_BITS'(1);

    always_comb begin
        led_next = 1'b0;
        case (mode)
            LED_ON:    led_next = 1'b1;
            LED_BLINK: led_next = phase;
            LED_PWM:   led_next = (pwm_cnt < duty);
            default:   led_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk_axi or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= LED_OFF;
            duty   <= '0;
            period <= '0;
            cnt    <= '0;
            phase  <= 1'b0;
            led    <= 1'b0;
        end else begin
            led <= led_next;
            // A write takes priority over a coincident tick; that tick is dropped.
            if (wr) begin
                mode   <= led_mode_t'(cfg_mode);
                duty   <= cfg_duty;
                period <= cfg_period;
                cnt    <= '0;
                phase  <= (led_mode_t'(cfg_mode) == LED_BLINK);
            end else if (mode == LED_BLINK && tick) begin
                if (cnt == last) begin
                    cnt   <= '0;
                    phase <= ~phase;
                end else begin
                    cnt <= cnt + PER_BITS'(1);
                end
            end
        end
    end

endmodule

// File: rtl/snicker_led_ctrl.sv
// Multi-channel LED controller: shared prescaler and PWM counter, config write decode.
module snicker_led_ctrl
    import snicker_led_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int PER_BITS = DEF_PER_BITS,
    localparam int CHAN_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk_axi,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    input  logic [PER_BITS-1:0] cfg_period,
    output logic [NUM_LEDS-1:0] led
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk_axi or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ready <= 1'b0;
            pre_cnt   <= '0;
            pwm_cnt   <= '0;
        end else begin
            cfg_ready <= 1'b1;
            pre_cnt   <= tick ? '0 : pre_cnt + PRE_W'(1);
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Channel indices at or above NUM_LEDS match no strobe, so such writes are dropped.
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        logic wr;
        assign wr = cfg_valid && cfg_ready && (cfg_chan == CHAN_W'(i));

        snicker_led_chan #(
            .PWM_BITS(PWM_BITS),
            .PER_BITS(PER_BITS)
        ) u_chan (
            .clk_axi   (clk_axi),
            .rst_n     (rst_n),
            .wr        (wr),
            .cfg_mode  (cfg_mode),
            .cfg_duty  (cfg_duty),
            .cfg_period(cfg_period),
            .tick      (tick),
            .pwm_cnt   (pwm_cnt),
            .led       (led[i])
        );
    end

endmodule

// File: tb/tb_snicker_led_ctrl.sv
// Randomized bench for snicker_led_ctrl against a cycle-count based reference model.
module tb_snicker_led_ctrl;

    localparam int TD      = 4;
    localparam int PWM     = 4;
    localparam int PWM_MOD = 1 << PWM;

    logic          clk_axi = 1'b0;
    logic          rst_n   = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [1:0]    cfg_chan  = '0;
    logic [1:0]    cfg_mode  = '0;
    logic [PWM-1:0] cfg_duty = '0;
    logic [15:0]   cfg_period = '0;
    logic          rdy4, rdy3;
    logic [3:0]    led4;
    logic [2:0]    led3;

    always #5 clk_axi = ~clk_axi;

    snicker_led_ctrl #(.NUM_LEDS(4), .TICK_DIV(TD), .PWM_BITS(PWM), .PER_BITS(16)) u_dut (
        .clk_axi(clk_axi), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(rdy4),
        .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
        .cfg_period(cfg_period), .led(led4)
    );

    // Three-channel instance on the same bus: writes to index 3 are out of range here.
    snicker_led_ctrl #(.NUM_LEDS(3), .TICK_DIV(TD), .PWM_BITS(PWM), .PER_BITS(16)) u_dut3 (
        .clk_axi(clk_axi), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(rdy3),
        .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
        .cfg_period(cfg_period), .led(led3)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n = 0;                  // index of the next rising edge since reset release
    int m_mode [4];
    int m_duty [4];
    int m_eff  [4];
    int m_w    [4];             // edge at which the channel was last written

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            m_mode[c] = 0; m_duty[c] = 0; m_eff[c] = 1; m_w[c] = 0;
        end
    endfunction

    // Blink phase from the number of ticks seen since the write, not from a counter.
    function automatic logic exp_led(int c, int e);
        logic r;
        int k;
        r = 1'b0;
        case (m_mode[c])
            1: r = 1'b1;
            2: begin
                k = e / TD - (m_w[c] + 1) / TD;
                r = ((k / m_eff[c]) % 2) == 0;
            end
            3: r = (e % PWM_MOD) < m_duty[c];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    task automatic cycle();
        logic [3:0] exp;
        int c;
        @(posedge clk_axi);
        for (int i = 0; i < 4; i++) exp[i] = exp_led(i, n);
        if (cfg_valid && n >= 1) begin
            c = int'(cfg_chan);
            m_mode[c] = int'(cfg_mode);
            m_duty[c] = int'(cfg_duty);
            m_eff[c]  = (cfg_period == 16'd0) ? 1 : int'(cfg_period);
            m_w[c]    = n;
        end
        #1;
        chk("led", 32'(led4), 32'(exp));
        chk("led3", 32'(led3), 32'(exp[2:0]));
        chk("ready", 32'(rdy4), 32'd1);
        n++;
    endtask

    task automatic idle(int cyc);
        repeat (cyc) cycle();
    endtask

    task automatic wr(int c, int m, int d, int p);
        int guard = 0;
        while (!rdy4 && guard < 10) begin
            cycle();
            guard++;
        end
        if (!rdy4) chk("ready_wait", 32'(rdy4), 32'd1);
        cfg_valid  = 1'b1;
        cfg_chan   = 2'(c);
        cfg_mode   = 2'(m);
        cfg_duty   = PWM'(d);
        cfg_period = 16'(p);
        cycle();
        cfg_valid  = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (4) begin
            @(negedge clk_axi);
            chk("rst_led", 32'(led4), 32'd0);
            chk("rst_ready", 32'(rdy4), 32'd0);
            chk("rst_ready3", 32'(rdy3), 32'd0);
        end
        rst_n = 1'b1;
        n = 0;
        idle(3);

        wr(2, 1, 0, 0);  idle(3);
        wr(2, 0, 0, 0);  idle(3);
        wr(0, 2, 0, 3);  idle(60);
        wr(0, 2, 0, 0);  idle(20);
        wr(1, 3, 5, 0);  idle(40);
        wr(1, 3, 0, 0);  idle(20);
        wr(1, 3, 15, 0); idle(20);

        // Write landing exactly on a tick edge.
        while ((n % TD) != TD - 1) cycle();
        wr(0, 2, 0, 3);  idle(40);
        wr(3, 1, 0, 0);  idle(5);

        repeat (2000) begin
            cfg_chan   = 2'($urandom_range(0, 3));
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_duty   = PWM'($urandom_range(0, PWM_MOD - 1));
            cfg_period = 16'($urandom_range(0, 4));
            cfg_valid  = ($urandom_range(0, 11) == 0);
            cycle();
            cfg_valid  = 1'b0;
        end

        // Asynchronous reset in the middle of a cycle while channels are active.
        wr(0, 2, 0, 1);
        wr(2, 1, 0, 0);
        idle(6);
        @(posedge clk_axi);
        #2 rst_n = 1'b0;
        #1;
        chk("async_led", 32'(led4), 32'd0);
        chk("async_led3", 32'(led3), 32'd0);
        chk("async_ready", 32'(rdy4), 32'd0);
        repeat (2) @(negedge clk_axi);
        model_reset();
        rst_n = 1'b1;
        n = 0;
        idle(10);
        wr(0, 2, 0, 2);  idle(30);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
